reg_file_sb: RTL and testbench

- Parametrised successor to the 16x8 register file: configurable data width and depth, two combinational read ports, one synchronous write port.
- Adds a power-up clear sweep, optional write-to-read bypass and a per-register pending-write scoreboard.
- Sits between decode (read, reserve) and writeback (write) in the pipelined core. Lets decode detect RAW hazards without a separate hazard table.

---
 rtl/reg_file_sb_pkg.sv | 17 +
 rtl/reg_file_sb_port.sv | 40 ++++
 rtl/reg_file_sb.sv | 123 ++++++++++++
 tb/tb_reg_file_sb.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared types and defaults for the scoreboarded register file.
// Decode-stage logic imports the default widths from here as well.
package reg_file_sb_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/reg_file_sb_port.sv
// One combinational read port: zero-gating, optional bypass of the
// in-flight write, and pending-write lookup.
module reg_file_sb_port
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYPASS = 1,
  parameter int DEPTH  = depth_of(ADDR_W)
) (
  input  logic                          ready,
  input  logic [ADDR_W-1:0]             rx,
  input  logic [DEPTH-1:0][DATA_W-1:0]  mem,
  input  logic [DEPTH-1:0]              busy,
  input  logic                          we,
  input  logic [ADDR_W-1:0]             wa,
  input  logic [DATA_W-1:0]             wd,
  output logic [DATA_W-1:0]             rdata,
  output logic                          rbusy
);

  logic hit;

  always_comb begin
    hit   = (BYPASS != 0) && we &&
            (wa == rx) && (wa != '0);
    rdata = '0;
    rbusy = 1'b0;
    if (ready && (rx != '0)) begin
      // a forwarded value is delivered now, so it is no longer pending
      if (hit) begin
        rdata = wd;
      end else begin
        rdata = mem[rx];
        rbusy = busy[rx];
      end
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with power-up clear sweep, two read ports,
// one write port and a per-entry pending-write scoreboard.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [DATA_W-1:0] read_a,
  output logic [DATA_W-1:0] read_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              ready,
  output logic              rsv_err
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  rf_state_e                   state_q, state_d;
  logic [ADDR_W-1:0]           clr_ptr_q, clr_ptr_d;
  logic [DEPTH-1:0]            busy_q, busy_d;
  logic                        rsv_err_q, rsv_err_d;
  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;

  assign ready   = (state_q == RUN);
  assign rsv_err = rsv_err_q;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    busy_d    = busy_q;
    rsv_err_d = 1'b0;
    mem_d     = mem_q;
    unique case (state_q)
      CLEAR: begin
        mem_d[clr_ptr_q] = '0;
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (we && (wa != '0)) begin
          mem_d[wa]  = wd;
          busy_d[wa] = 1'b0;
        end
        // reservation after the write so a same-entry collision stays busy
        if (rsv_en && (rsv_addr != '0)) begin
          busy_d[rsv_addr] = 1'b1;
          rsv_err_d = busy_q[rsv_addr];
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= ADDR_W'(1);
      busy_q    <= '0;
      rsv_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
      rsv_err_q <= rsv_err_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  reg_file_sb_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS),
    .DEPTH  (DEPTH)
  ) u_port_a (
    .ready (ready),
    .rx    (ra),
    .mem   (mem_q),
    .busy  (busy_q),
    .we    (we),
    .wa    (wa),
    .wd    (wd),
    .rdata (read_a),
    .rbusy (busy_a)
  );

  reg_file_sb_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS),
    .DEPTH  (DEPTH)
  ) u_port_b (
    .ready (ready),
    .rx    (rb),
    .mem   (mem_q),
    .busy  (busy_q),
    .we    (we),
    .wa    (wa),
    .wd    (wd),
    .rdata (read_b),
    .rbusy (busy_b)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: BYPASS=1 and BYPASS=0 instances
// share one stimulus stream.
module tb_reg_file_sb;

  logic       clk;
  logic       rst;
  logic [3:0] ra, rb, wa, rsv_addr;
  logic [7:0] wd;
  logic       we, rsv_en;

  logic [7:0] read_a, read_b, read_a0, read_b0;
  logic       busy_a, busy_b, busy_a0, busy_b0;
  logic       ready, ready0, rsv_err, rsv_err0;

  int errors = 0;
  int checks = 0;

  reg_file_sb #(.DATA_W(8), .ADDR_W(4), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .ra(ra), .rb(rb),
    .read_a(read_a), .read_b(read_b),
    .busy_a(busy_a), .busy_b(busy_b),
    .we(we), .wa(wa), .wd(wd),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .ready(ready), .rsv_err(rsv_err)
  );

  reg_file_sb #(.DATA_W(8), .ADDR_W(4), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .ra(ra), .rb(rb),
    .read_a(read_a0), .read_b(read_b0),
    .busy_a(busy_a0), .busy_b(busy_b0),
    .we(we), .wa(wa), .wd(wd),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .ready(ready0), .rsv_err(rsv_err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       rsv_en;
    logic [3:0] rsv_addr;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [7:0] e_ra;
    logic [7:0] e_rb;
    logic       e_ba;
    logic       e_bb;
    logic       e_err;
    logic [7:0] e0_ra;
    logic       e0_ba;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic sweep_wait(input string nm);
    int cnt;
    cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    while (!ready && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    we     = 1'b0;
    rsv_en = 1'b0;
    chk({nm, "_ready"}, 32'(ready), 32'd1);
    chk({nm, "_cycles"}, 32'(cnt), 32'd15);
    chk({nm, "_ready0"}, 32'(ready0), 32'd1);
  endtask

  task automatic scan_all(input string nm);
    for (int i = 0; i < 16; i++) begin
      ra = 4'(i);
      rb = 4'(15 - i);
      #1;
      chk({nm, "_rd_a"}, 32'(read_a), 32'd0);
      chk({nm, "_bz_a"}, 32'(busy_a), 32'd0);
      chk({nm, "_rd_b"}, 32'(read_b), 32'd0);
      chk({nm, "_bz_b"}, 32'(busy_b), 32'd0);
      chk({nm, "_rd_a0"}, 32'(read_a0), 32'd0);
      chk({nm, "_bz_a0"}, 32'(busy_a0), 32'd0);
    end
    chk({nm, "_err"}, 32'(rsv_err), 32'd0);
  endtask

  initial begin
    vt[0]  = '{1, 5, 8'hA7, 0, 0, 5, 0, 8'hA7, 8'h00, 0, 0, 0, 8'h00, 0};
    vt[1]  = '{0, 0, 8'h00, 0, 0, 5, 5, 8'hA7, 8'hA7, 0, 0, 0, 8'hA7, 0};
    vt[2]  = '{1, 0, 8'h5A, 0, 0, 0, 5, 8'h00, 8'hA7, 0, 0, 0, 8'h00, 0};
    vt[3]  = '{0, 0, 8'h00, 1, 3, 3, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0};
    vt[4]  = '{0, 0, 8'h00, 0, 0, 3, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 1};
    vt[5]  = '{0, 0, 8'h00, 1, 3, 3, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 1};
    vt[6]  = '{0, 0, 8'h00, 0, 0, 3, 0, 8'h00, 8'h00, 1, 0, 1, 8'h00, 1};
    vt[7]  = '{1, 3, 8'h11, 0, 0, 3, 0, 8'h11, 8'h00, 0, 0, 0, 8'h00, 1};
    vt[8]  = '{0, 0, 8'h00, 0, 0, 3, 0, 8'h11, 8'h00, 0, 0, 0, 8'h11, 0};
    vt[9]  = '{1, 7, 8'hC3, 1, 7, 7, 3, 8'hC3, 8'h11, 0, 0, 0, 8'h00, 0};
    vt[10] = '{0, 0, 8'h00, 0, 0, 7, 0, 8'hC3, 8'h00, 1, 0, 0, 8'hC3, 1};
    vt[11] = '{0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0};
    vt[12] = '{0, 0, 8'h00, 0, 0, 0, 7, 8'h00, 8'hC3, 0, 1, 0, 8'h00, 0};

    rst = 1'b1;
    ra = 4'd5; rb = 4'd6;
    we = 1'b1; wa = 4'd5; wd = 8'hFF;
    rsv_en = 1'b1; rsv_addr = 4'd6;
    #2;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_err", 32'(rsv_err), 32'd0);
    chk("rst_rd_a", 32'(read_a), 32'd0);
    chk("rst_bz_b", 32'(busy_b), 32'd0);

    // traffic held throughout the sweep must be ignored
    sweep_wait("sweep1");
    scan_all("clear1");

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      we       = vt[i].we;
      wa       = vt[i].wa;
      wd       = vt[i].wd;
      rsv_en   = vt[i].rsv_en;
      rsv_addr = vt[i].rsv_addr;
      ra       = vt[i].ra;
      rb       = vt[i].rb;
      #1;
      chk($sformatf("v%0d_rd_a", i), 32'(read_a), 32'(vt[i].e_ra));
      chk($sformatf("v%0d_rd_b", i), 32'(read_b), 32'(vt[i].e_rb));
      chk($sformatf("v%0d_bz_a", i), 32'(busy_a), 32'(vt[i].e_ba));
      chk($sformatf("v%0d_bz_b", i), 32'(busy_b), 32'(vt[i].e_bb));
      chk($sformatf("v%0d_err", i), 32'(rsv_err), 32'(vt[i].e_err));
      chk($sformatf("v%0d_rd_a0", i), 32'(read_a0), 32'(vt[i].e0_ra));
      chk($sformatf("v%0d_bz_a0", i), 32'(busy_a0), 32'(vt[i].e0_ba));
    end

    @(negedge clk);
    we = 1'b0; rsv_en = 1'b1; rsv_addr = 4'd2;
    @(negedge clk);
    rsv_addr = 4'd9;
    @(negedge clk);
    rsv_en = 1'b0;
    we = 1'b1; wa = 4'd4; wd = 8'h5C;
    @(negedge clk);
    we = 1'b0; ra = 4'd2; rb = 4'd9;
    #1;
    chk("mid_bz_a", 32'(busy_a), 32'd1);
    chk("mid_bz_b", 32'(busy_b), 32'd1);
    ra = 4'd4;
    #1;
    chk("mid_rd4", 32'(read_a), 32'h5C);
    chk("mid_rd4_0", 32'(read_a0), 32'h5C);
    ra = 4'd2;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_bz_a", 32'(busy_a), 32'd0);
    chk("arst_bz_b", 32'(busy_b), 32'd0);
    chk("arst_ready", 32'(ready), 32'd0);
    chk("arst_ready0", 32'(ready0), 32'd0);

    sweep_wait("sweep2");
    ra = 4'd4;
    #1;
    chk("resweep_rd4", 32'(read_a), 32'd0);
    scan_all("clear2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
